pong_game_ctrl: RTL
===================

Name: pong_game_ctrl

Overview:
- Game-sequencing controller for the Pong datapath.
- Decodes UART command bytes, counts frames from the VGA vertical sync, keeps both players' scores, and runs the serve/play/point/pause/game-over state machine.
- Drives ball enable, serve direction and score values into the Pong game logic.
- Sits between the UART receiver / sync generator and the Pong game block.

Parameters:
- c_SCORE_LIMIT, 9, score that ends the game (1..15).
- c_SERVE_FRAMES, 60, frames held in SERVE before the ball is released (>=1).
- c_POINT_FRAMES, 30, frames held in POINT after a score (>=1).

Ports:
- i_Clk  in  1  system clock (25 MHz pixel clock).
- i_Rst_L  in  1  synchronous active-low reset, sampled on the rising edge of i_Clk.
- i_VSync  in  1  VGA vertical sync from the sync-pulse generator; high during active rows.
- i_RX_DV  in  1  one-cycle strobe: i_RX_Byte is valid.
- i_RX_Byte  in  8  received UART byte.
- i_P1_Miss  in  1  one-cycle pulse: ball passed P1's (left) edge.
- i_P2_Miss  in  1  one-cycle pulse: ball passed P2's (right) edge.
- o_Game_Active  out  1  ball motion enable; high only in PLAY.
- o_Serve_Dir  out  1  0 = serve toward P1, 1 = serve toward P2.
- o_P1_Score  out  4  P1 score.
- o_P2_Score  out  4  P2 score.
- o_State  out  3  current state encoding.
- o_Winner  out  2  00 none, 01 P1, 10 P2.

Behaviour:
- Reset: while i_Rst_L=0 at a rising edge, state=IDLE, scores=0, frame counter=0, saved state=IDLE, o_Serve_Dir=0, o_Winner=00, o_Game_Active=0, and the i_VSync history register is set to 0. Reset takes effect on the same edge in any state.
- All outputs are registered and reflect the current state the cycle after the transition edge.
- Frame tick: one-cycle internal pulse when i_VSync was 1 on the previous cycle and is 0 now (end of active video).
- Commands are accepted only when i_RX_DV=1:
  - 0x53 'S' = start.
  - 0x50 'P' = pause toggle.
  - 0x52 'R' = abort.
  - All other bytes are ignored.
- State encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSED=4, GAME_OVER=5.
- 'R' in any state: go to IDLE, clear scores, frame counter and o_Winner. Highest priority.
- IDLE: on 'S', clear scores, set o_Serve_Dir=0, clear the frame counter, go to SERVE.
- SERVE: count frame ticks. On the tick that makes the count equal c_SERVE_FRAMES, clear the counter and go to PLAY.
- PLAY: o_Game_Active=1. Miss handling:
  - i_P1_Miss alone: P2 score +1, o_Serve_Dir=0.
  - i_P2_Miss alone: P1 score +1, o_Serve_Dir=1.
  - Both on the same cycle: no score change, o_Serve_Dir unchanged, go to SERVE.
  - After a single scoring miss: if the new score equals c_SCORE_LIMIT, set o_Winner and go to GAME_OVER; otherwise go to POINT.
  - A miss on the same cycle as 'P' is processed and 'P' is dropped.
- POINT: count frame ticks to c_POINT_FRAMES, then clear the counter and go to SERVE.
- Pause entry: 'P' in SERVE, PLAY or POINT saves the current state and goes to PAUSED. The frame counter is held.
- PAUSED:
  - Frame ticks and miss pulses are ignored.
  - 'P' returns to the saved state with the counter intact.
  - 'S' is ignored.
- GAME_OVER: scores and o_Winner are held. 'S' clears scores and o_Winner, sets o_Serve_Dir=0 and goes to SERVE. 'P' is ignored.
- Miss pulses outside PLAY are ignored.
- Scores saturate at 15; with a legal c_SCORE_LIMIT they never exceed the limit.
- Frame counter width is ceil(log2(max(c_SERVE_FRAMES, c_POINT_FRAMES)+1)).
- Latency: command byte to state change is 1 cycle. Final frame tick to PLAY/SERVE is 1 cycle.

Test Plan:
- Reset then IDLE start: hold i_Rst_L=0 for 3 cycles, release, then send 0x53 -> o_State=1, scores 0/0, o_Game_Active=0; after exactly 60 VSync falling edges o_State=2 and o_Game_Active=1.
- Scoring: in PLAY pulse i_P1_Miss -> o_P2_Score=1, o_Serve_Dir=0, o_State=3; after 30 frames o_State=1; after 60 more frames o_State=2.
- Game over: with c_SCORE_LIMIT=3, give P1 three i_P2_Miss points -> o_P1_Score=3, o_Winner=01, o_State=5; further misses leave scores unchanged; 0x53 -> scores 0/0, o_Winner=00, o_State=1.
- Pause: in SERVE after 20 frames send 0x50 -> o_State=4; 100 frames and an i_P1_Miss pulse cause no change; send 0x50 -> o_State=1 and PLAY is reached after 40 more frames.
- Collisions:
  - i_P1_Miss and i_P2_Miss on the same cycle in PLAY -> scores unchanged, o_State=1.
  - i_P2_Miss with i_RX_DV=1 and byte 0x50 on the same cycle -> P1 +1, o_State=3 (not PAUSED).
  - 0x52 during PAUSED with scores 2/1 -> o_State=0, scores 0/0.
- Reset mid-operation: assert i_Rst_L=0 for 1 cycle in PLAY with scores 4/5 -> next cycle o_State=0, scores 0/0, o_Game_Active=0; bytes other than 0x53/0x50/0x52 (e.g. 0x41) in IDLE cause no change.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl
//   Game-sequencing controller for the Pong datapath. Decodes UART command
//   bytes ('S' start, 'P' pause toggle, 'R' abort), counts frames from the
//   VGA vertical sync, keeps both players' scores and sequences
//   IDLE -> SERVE -> PLAY -> POINT/GAME_OVER, with PAUSED reachable from
//   SERVE, PLAY and POINT.
//
// Ports
//   i_Clk          system (pixel) clock
//   i_Rst_L        synchronous active-low reset
//   i_VSync        VGA vertical sync, high during active rows
//   i_RX_DV        one-cycle strobe, i_RX_Byte valid
//   i_RX_Byte      received UART byte
//   i_P1_Miss      one-cycle pulse, ball passed P1's (left) edge
//   i_P2_Miss      one-cycle pulse, ball passed P2's (right) edge
//   o_Game_Active  ball motion enable, high only in PLAY
//   o_Serve_Dir    0 = serve toward P1, 1 = serve toward P2
//   o_P1_Score     P1 score
//   o_P2_Score     P2 score
//   o_State        current state encoding
//   o_Winner       00 none, 01 P1, 10 P2
// ---------------------------------------------------------------------------
module pong_game_ctrl #(
    parameter int c_SCORE_LIMIT  = 9,
    parameter int c_SERVE_FRAMES = 60,
    parameter int c_POINT_FRAMES = 30
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_VSync,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    input  logic       i_P1_Miss,
    input  logic       i_P2_Miss,
    output logic       o_Game_Active,
    output logic       o_Serve_Dir,
    output logic [3:0] o_P1_Score,
    output logic [3:0] o_P2_Score,
    output logic [2:0] o_State,
    output logic [1:0] o_Winner
);

    typedef enum logic [2:0] {
        s_IDLE      = 3'd0,
        s_SERVE     = 3'd1,
        s_PLAY      = 3'd2,
        s_POINT     = 3'd3,
        s_PAUSED    = 3'd4,
        s_GAME_OVER = 3'd5
    } t_state;

    localparam int c_MAX_FRAMES = (c_SERVE_FRAMES > c_POINT_FRAMES) ?
                                  c_SERVE_FRAMES : c_POINT_FRAMES;
    localparam int c_CNT_W      = $clog2(c_MAX_FRAMES + 1);

    localparam logic [c_CNT_W-1:0] c_SERVE_END = c_CNT_W'(c_SERVE_FRAMES);
    localparam logic [c_CNT_W-1:0] c_POINT_END = c_CNT_W'(c_POINT_FRAMES);
    localparam logic [3:0]         c_LIMIT     = 4'(c_SCORE_LIMIT);

    t_state               r_state, r_saved;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_p1, r_p2;
    logic                 r_dir, r_active, r_vsync_d;
    logic [1:0]           r_winner;

    t_state               w_state_nx, w_saved_nx;
    logic [c_CNT_W-1:0]   w_cnt_nx, w_cnt_inc;
    logic [3:0]           w_p1_nx, w_p2_nx, w_p1_inc, w_p2_inc;
    logic                 w_dir_nx, w_active_nx;
    logic [1:0]           w_winner_nx;
    logic                 w_tick, w_cmd_s, w_cmd_p, w_cmd_r;

    // End of active video: VSync was high last cycle and is low now.
    assign w_tick    = r_vsync_d & ~i_VSync;
    assign w_cmd_s   = i_RX_DV && (i_RX_Byte == 8'h53);
    assign w_cmd_p   = i_RX_DV && (i_RX_Byte == 8'h50);
    assign w_cmd_r   = i_RX_DV && (i_RX_Byte == 8'h52);
    assign w_cnt_inc = r_cnt + c_CNT_W'(1);
    // Scores saturate so a bad limit can never wrap them back to zero.
    assign w_p1_inc  = (r_p1 == 4'hF) ? 4'hF : r_p1 + 4'd1;
    assign w_p2_inc  = (r_p2 == 4'hF) ? 4'hF : r_p2 + 4'd1;

    // State register: holds the FSM state and all datapath registers.
    always_ff @(posedge i_Clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples the pre-edge values regardless of statement order.
        if (!i_Rst_L) begin
            r_state   <= s_IDLE;
            r_saved   <= s_IDLE;
            r_cnt     <= '0;
            r_p1      <= '0;
            r_p2      <= '0;
            r_dir     <= 1'b0;
            r_winner  <= 2'b00;
            r_active  <= 1'b0;
            r_vsync_d <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_saved   <= w_saved_nx;
            r_cnt     <= w_cnt_nx;
            r_p1      <= w_p1_nx;
            r_p2      <= w_p2_nx;
            r_dir     <= w_dir_nx;
            r_winner  <= w_winner_nx;
            r_active  <= w_active_nx;
            r_vsync_d <= i_VSync;
        end
    end

    // Next-state logic, including the score / counter / direction updates
    // that belong to each transition.
    always_comb begin
        // NOTE: every signal gets a hold-value default first, so no path
        // through the case leaves one unassigned and infers a latch.
        w_state_nx  = r_state;
        w_saved_nx  = r_saved;
        w_cnt_nx    = r_cnt;
        w_p1_nx     = r_p1;
        w_p2_nx     = r_p2;
        w_dir_nx    = r_dir;
        w_winner_nx = r_winner;

        if (w_cmd_r) begin
            w_state_nx  = s_IDLE;
            w_cnt_nx    = '0;
            w_p1_nx     = '0;
            w_p2_nx     = '0;
            w_winner_nx = 2'b00;
        end else begin
            case (r_state)
                s_IDLE, s_GAME_OVER: begin
                    if (w_cmd_s) begin
                        w_state_nx  = s_SERVE;
                        w_cnt_nx    = '0;
                        w_p1_nx     = '0;
                        w_p2_nx     = '0;
                        w_dir_nx    = 1'b0;
                        w_winner_nx = 2'b00;
                    end
                end
                s_SERVE, s_POINT: begin
                    if (w_cmd_p) begin
                        w_saved_nx = r_state;
                        w_state_nx = s_PAUSED;
                    end else if (w_tick) begin
                        if (w_cnt_inc == ((r_state == s_SERVE) ? c_SERVE_END : c_POINT_END)) begin
                            w_cnt_nx   = '0;
                            w_state_nx = (r_state == s_SERVE) ? s_PLAY : s_SERVE;
                        end else begin
                            w_cnt_nx = w_cnt_inc;
                        end
                    end
                end
                s_PLAY: begin
                    // A miss outranks a simultaneous pause request.
                    if (i_P1_Miss && i_P2_Miss) begin
                        w_state_nx = s_SERVE;
                        w_cnt_nx   = '0;
                    end else if (i_P1_Miss) begin
                        w_p2_nx  = w_p2_inc;
                        w_dir_nx = 1'b0;
                        w_cnt_nx = '0;
                        if (w_p2_inc == c_LIMIT) begin
                            w_winner_nx = 2'b10;
                            w_state_nx  = s_GAME_OVER;
                        end else begin
                            w_state_nx  = s_POINT;
                        end
                    end else if (i_P2_Miss) begin
                        w_p1_nx  = w_p1_inc;
                        w_dir_nx = 1'b1;
                        w_cnt_nx = '0;
                        if (w_p1_inc == c_LIMIT) begin
                            w_winner_nx = 2'b01;
                            w_state_nx  = s_GAME_OVER;
                        end else begin
                            w_state_nx  = s_POINT;
                        end
                    end else if (w_cmd_p) begin
                        w_saved_nx = s_PLAY;
                        w_state_nx = s_PAUSED;
                    end
                end
                s_PAUSED: begin
                    if (w_cmd_p) begin
                        w_state_nx = r_saved;
                    end
                end
                default: w_state_nx = s_IDLE;
            endcase
        end
    end

    // Output logic: decoded from the next state so the registered enable
    // lines up with o_State on the cycle after the transition edge.
    always_comb begin
        w_active_nx = (w_state_nx == s_PLAY);
    end

    assign o_Game_Active = r_active;
    assign o_Serve_Dir   = r_dir;
    assign o_P1_Score    = r_p1;
    assign o_P2_Score    = r_p2;
    assign o_State       = r_state;
    assign o_Winner      = r_winner;

endmodule
